// File: rtl/cpu_pkg.sv
// Shared execute-stage types: datapath width and the multiplier FSM states.
package cpu_pkg;
    localparam int CPU_W = 16;
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
endpackage

// File: rtl/seq_mul_if.sv
// Handshake/data bundle between the execute-stage control and seq_mul.
// res_hi/ovf exist only when SEQ_MUL_HI_EN is defined.
interface seq_mul_if #(parameter int N = cpu_pkg::CPU_W);
    logic         start;
    logic [N-1:0] inp1;
    logic [N-1:0] inp2;
    logic         busy;
    logic         done;
    logic [N-1:0] Res;
`ifdef SEQ_MUL_HI_EN
    logic [N-1:0] res_hi;
    logic         ovf;

    modport master (output start, inp1, inp2, input busy, done, Res, res_hi, ovf);
    modport slave  (input start, inp1, inp2, output busy, done, Res, res_hi, ovf);
`else
    modport master (output start, inp1, inp2, input busy, done, Res);
    modport slave  (input start, inp1, inp2, output busy, done, Res);
`endif
endinterface

// File: rtl/seq_mul_step.sv
// One shift-add iteration: conditionally add mcand into the high half, then
// shift {carry,acc_hi,mq} right by one so the carry lands in acc_hi[N-1].
module seq_mul_step #(
    parameter int N = cpu_pkg::CPU_W
) (
    input  logic [N-1:0] mcand_i,
    input  logic [N-1:0] acc_i,
    input  logic [N-1:0] mq_i,
    output logic [N-1:0] acc_o,
    output logic [N-1:0] mq_o
);
    logic [N:0] sum;

    assign sum          = {1'b0, acc_i} + (mq_i[0] ? {1'b0, mcand_i} : '0);
    assign {acc_o, mq_o} = {sum, mq_i[N-1:1]};
endmodule

// File: rtl/seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock, N-cycle latency.
// Define SEQ_MUL_HI_EN to export the high product half (res_hi) and overflow flag (ovf).
module seq_mul
    import cpu_pkg::*;
#(
    parameter int N = CPU_W
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mul_if.slave  mif
);
    localparam int CW = $clog2(N + 1);

    mul_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  mcand_q, mcand_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  mq_q, mq_d;
    logic [N-1:0]  res_q, res_d;
    logic [N-1:0]  step_acc, step_mq;
`ifdef SEQ_MUL_HI_EN
    logic [N-1:0]  hi_q, hi_d;
`endif

    seq_mul_step #(.N(N)) u_step (
        .mcand_i (mcand_q),
        .acc_i   (acc_q),
        .mq_i    (mq_q),
        .acc_o   (step_acc),
        .mq_o    (step_mq)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        res_d   = res_q;
`ifdef SEQ_MUL_HI_EN
        hi_d    = hi_q;
`endif
        unique case (state_q)
            MUL_RUN: begin
                acc_d   = step_acc;
                mq_d    = step_mq;
                count_d = count_q + 1'b1;
                if (count_q == CW'(N - 1)) begin
                    res_d   = step_mq;
`ifdef SEQ_MUL_HI_EN
                    hi_d    = step_acc;
`endif
                    state_d = MUL_DONE;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise
                state_d = MUL_IDLE;
                if (mif.start) begin
                    mcand_d = mif.inp1;
                    acc_d   = '0;
                    mq_d    = mif.inp2;
                    count_d = '0;
                    state_d = MUL_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            res_q   <= '0;
`ifdef SEQ_MUL_HI_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            res_q   <= res_d;
`ifdef SEQ_MUL_HI_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign mif.busy = (state_q == MUL_RUN);
    assign mif.done = (state_q == MUL_DONE);
    assign mif.Res  = res_q;
`ifdef SEQ_MUL_HI_EN
    assign mif.res_hi = hi_q;
    assign mif.ovf    = |hi_q;
`endif
endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: stimulus queues expected products and done cycles,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_mul;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_mul_if #(.N(N)) mif ();
    seq_mul #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .mif(mif));

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mif.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_lo", mif.Res, e.prod[N-1:0]);
                chk("latency", cyc, e.cyc);
`ifdef SEQ_MUL_HI_EN
                chk("res_hi", mif.res_hi, e.prod[2*N-1:N]);
                chk("ovf", mif.ovf, |e.prod[2*N-1:N]);
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (mif.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got busy=%0b after %0d cycles, expected 0", mif.busy, n);
        end
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] prod);
        wait_ready();
        mif.start = 1'b1;
        mif.inp1  = a;
        mif.inp2  = b;
        sb.push_back('{prod, cyc + 1 + N});
        @(negedge clk);
        mif.start = 1'b0;
        mif.inp1  = N'($urandom);
        mif.inp2  = N'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [N-1:0] a, b;
        rst_n     = 1'b0;
        mif.start = 1'b0;
        mif.inp1  = '0;
        mif.inp2  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", mif.busy, 0);
        chk("rst_done", mif.done, 0);
        chk("rst_res", mif.Res, 0);
`ifdef SEQ_MUL_HI_EN
        chk("rst_res_hi", mif.res_hi, 0);
        chk("rst_ovf", mif.ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 3*5: busy exactly N cycles, then one-cycle done
        issue(16'd3, 16'd5, 32'd15);
        nb = 0;
        while (mif.busy === 1'b1 && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        chk("busy_cycles", nb, N);
        chk("done_after_busy", mif.done, 1);
        @(negedge clk);
        chk("done_one_cycle", mif.done, 0);

        // all-ones: exercises the carry into acc_hi
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001);

        // zero multiplicand, then back-to-back start in DONE
        issue(16'h0000, 16'h1234, 32'h0);
        nb = 0;
        while (mif.done !== 1'b1 && nb < 40) begin
            @(negedge clk);
            nb++;
        end
        chk("zero_done_seen", mif.done, 1);
        issue(16'h0007, 16'h0009, 32'd63);
        chk("b2b_busy", mif.busy, 1);
        chk("b2b_done_single", mif.done, 0);

        // start during RUN is ignored
        issue(16'd200, 16'd257, 32'h0000_C8C8);
        repeat (4) @(negedge clk);
        mif.start = 1'b1;
        mif.inp1  = 16'hFFFF;
        mif.inp2  = 16'h0002;
        @(negedge clk);
        mif.start = 1'b0;

        // async reset mid-RUN
        issue(16'h00FF, 16'h0101, 32'h0000_FFFF);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_busy", mif.busy, 0);
        chk("arst_done", mif.done, 0);
        chk("arst_res", mif.Res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h1234, 16'h0010, 32'h0001_2340);

        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            issue(a, b, {{N{1'b0}}, a} * {{N{1'b0}}, b});
        end

        nb = 0;
        while (sb.size() != 0 && nb < 100) begin
            @(negedge clk);
            nb++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
